// File: rtl/cache_data.sv
// Direct-mapped, write-back, write-allocate data cache for the memory stage.
// Hits complete combinationally; misses stall while a victim is written back and the line is refilled.
module cache_data #(
  parameter int ARCH_BITS        = 32,
  parameter int MEMORY_LINE_BITS = 128,
  parameter int NUM_LINES        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reqValid,
  input  logic                        reqWrite,
  input  logic                        reqByte,
  input  logic [ARCH_BITS-1:0]        reqAddr,
  input  logic [ARCH_BITS-1:0]        reqWData,
  output logic [ARCH_BITS-1:0]        rData,
  output logic                        stall,
  output logic [ARCH_BITS-1:0]        memReadAddr,
  output logic                        memReadReq,
  input  logic [MEMORY_LINE_BITS-1:0] memData,
  input  logic                        memDataValid,
  output logic [ARCH_BITS-1:0]        memWriteAddr,
  output logic [MEMORY_LINE_BITS-1:0] memWriteData,
  output logic                        memWriteReq,
  input  logic                        memWriteDone
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ARCH_BITS - 4 - IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WBACK = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [NUM_LINES-1:0]        valid_q;
  logic [NUM_LINES-1:0]        dirty_q;
  logic [TAG_W-1:0]            tag_q  [NUM_LINES];
  logic [MEMORY_LINE_BITS-1:0] data_q [NUM_LINES];

  logic                        rd_req_q, rd_req_d;
  logic                        wr_req_q, wr_req_d;
  logic [ARCH_BITS-1:0]        rd_addr_q, rd_addr_d;
  logic [ARCH_BITS-1:0]        wr_addr_q, wr_addr_d;
  logic [MEMORY_LINE_BITS-1:0] wr_data_q, wr_data_d;

  logic [IDX_W-1:0]            idx_s;
  logic [TAG_W-1:0]            tag_s;
  logic [6:0]                  byte_off_s;
  logic [6:0]                  word_off_s;
  logic                        hit_s;
  logic                        fill_we_s;
  logic                        wb_done_s;
  logic                        store_we_s;
  logic [MEMORY_LINE_BITS-1:0] line_rd_s;
  logic [MEMORY_LINE_BITS-1:0] line_wr_s;
  logic [ARCH_BITS-1:0]        rdata_s;

  assign idx_s      = reqAddr[4 +: IDX_W];
  assign tag_s      = reqAddr[ARCH_BITS-1 -: TAG_W];
  assign byte_off_s = {reqAddr[3:0], 3'b000};
  assign word_off_s = {reqAddr[3:2], 5'b00000};
  assign line_rd_s  = data_q[idx_s];
  assign hit_s      = reqValid & valid_q[idx_s] & (tag_q[idx_s] == tag_s);
  assign fill_we_s  = (state_q == FILL) & memDataValid;
  assign wb_done_s  = (state_q == WBACK) & memWriteDone;
  assign store_we_s = (state_q == IDLE) & hit_s & reqWrite;

  // Combinational load data and store merge for the addressed line
  always_comb begin
    rdata_s   = {ARCH_BITS{1'b0}};
    line_wr_s = line_rd_s;
    if (hit_s) begin
      if (reqByte) begin
        rdata_s = {{(ARCH_BITS-8){1'b0}}, line_rd_s[byte_off_s +: 8]};
        line_wr_s[byte_off_s +: 8] = reqWData[7:0];
      end else begin
        rdata_s = line_rd_s[word_off_s +: ARCH_BITS];
        line_wr_s[word_off_s +: ARCH_BITS] = reqWData;
      end
    end else begin
      rdata_s = {ARCH_BITS{1'b0}};
    end
  end

  assign rData = rdata_s;
  assign stall = (state_q != IDLE) | (reqValid & ~hit_s);

  // Miss sequencing and registered memory-request outputs
  always_comb begin
    state_d   = state_q;
    rd_req_d  = rd_req_q;
    wr_req_d  = wr_req_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (reqValid && !hit_s) begin
          rd_addr_d = {reqAddr[ARCH_BITS-1:4], 4'b0000};
          if (valid_q[idx_s] && dirty_q[idx_s]) begin
            state_d   = WBACK;
            wr_req_d  = 1'b1;
            wr_addr_d = {tag_q[idx_s], idx_s, 4'b0000};
            wr_data_d = line_rd_s;
          end else begin
            state_d  = FILL;
            rd_req_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WBACK: begin
        if (memWriteDone) begin
          state_d  = FILL;
          wr_req_d = 1'b0;
          rd_req_d = 1'b1;
        end else begin
          state_d = WBACK;
        end
      end
      FILL: begin
        if (memDataValid) begin
          state_d  = IDLE;
          rd_req_d = 1'b0;
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d  = IDLE;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
      end
    endcase
  end

  // Control state and memory-request registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_addr_q <= {ARCH_BITS{1'b0}};
      wr_addr_q <= {ARCH_BITS{1'b0}};
      wr_data_q <= {MEMORY_LINE_BITS{1'b0}};
    end else begin
      state_q   <= state_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Per-line valid/dirty/tag bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= {NUM_LINES{1'b0}};
      dirty_q <= {NUM_LINES{1'b0}};
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i] <= {TAG_W{1'b0}};
      end
    end else begin
      if (fill_we_s) begin
        valid_q[idx_s] <= 1'b1;
        dirty_q[idx_s] <= 1'b0;
        tag_q[idx_s]   <= tag_s;
      end else if (wb_done_s) begin
        dirty_q[idx_s] <= 1'b0;
      end else if (store_we_s) begin
        dirty_q[idx_s] <= 1'b1;
      end else begin
        dirty_q <= dirty_q;
      end
    end
  end

  // Line data survives reset; only fills and store hits modify it
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      data_q[idx_s] <= memData;
    end else if (store_we_s) begin
      data_q[idx_s] <= line_wr_s;
    end else begin
      data_q[idx_s] <= data_q[idx_s];
    end
  end

  assign memReadReq   = rd_req_q;
  assign memReadAddr  = rd_addr_q;
  assign memWriteReq  = wr_req_q;
  assign memWriteAddr = wr_addr_q;
  assign memWriteData = wr_data_q;

endmodule

// File: tb/tb_cache_data.sv
// Directed self-checking bench for cache_data: fills, hits, stores, write-back, reset abort.
module tb_cache_data;

  logic         clk = 1'b0;
  logic         rst;
  logic         reqValid, reqWrite, reqByte;
  logic [31:0]  reqAddr, reqWData;
  logic [31:0]  rData;
  logic         stall;
  logic [31:0]  memReadAddr, memWriteAddr;
  logic         memReadReq, memWriteReq;
  logic [127:0] memData, memWriteData;
  logic         memDataValid, memWriteDone;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] LINE_A = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] LINE_B = 128'h77777777_66666666_55555555_44444444;
  localparam logic [127:0] LINE_V = 128'h33333333_CAFEF00D_1111AB11_00000000;
  localparam logic [127:0] LINE_C = 128'hBBBBBBBB_AAAAAAAA_99999999_88888888;
  localparam logic [127:0] LINE_D = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] LINE_E = 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C;

  cache_data #(.ARCH_BITS(32), .MEMORY_LINE_BITS(128), .NUM_LINES(4)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqWrite(reqWrite), .reqByte(reqByte),
    .reqAddr(reqAddr), .reqWData(reqWData),
    .rData(rData), .stall(stall),
    .memReadAddr(memReadAddr), .memReadReq(memReadReq),
    .memData(memData), .memDataValid(memDataValid),
    .memWriteAddr(memWriteAddr), .memWriteData(memWriteData),
    .memWriteReq(memWriteReq), .memWriteDone(memWriteDone)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic w, input logic b,
                     input logic [31:0] a, input logic [31:0] d);
    reqValid = v; reqWrite = w; reqByte = b; reqAddr = a; reqWData = d;
    #1;
  endtask

  task automatic fill_pulse(input logic [127:0] line);
    memData = line; memDataValid = 1'b1;
    tick();
    memDataValid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    memData = 128'h0; memDataValid = 1'b0; memWriteDone = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (rData !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rData); end
    n_checks++; if ({memReadReq, memWriteReq} !== 2'b00) begin n_fail++; $display("FAIL reset_reqs: got %b want 00", {memReadReq, memWriteReq}); end
    n_checks++; if (memReadAddr !== 32'h0 || memWriteAddr !== 32'h0) begin n_fail++; $display("FAIL reset_addrs: got %h/%h want 0/0", memReadAddr, memWriteAddr); end
    n_checks++; if (memWriteData !== 128'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", memWriteData); end
  endtask

  task automatic test_fill_hit();
    req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL miss_stall: got %b want 1", stall); end
    tick();
    n_checks++; if (memReadReq !== 1'b1 || memWriteReq !== 1'b0) begin n_fail++; $display("FAIL fill_req: got rd=%b wr=%b want 1/0", memReadReq, memWriteReq); end
    n_checks++; if (memReadAddr !== 32'h100) begin n_fail++; $display("FAIL fill_addr: got %h want 00000100", memReadAddr); end
    tick();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fill_wait_stall: got %b want 1", stall); end
    fill_pulse(LINE_A);
    n_checks++; if (stall !== 1'b0 || rData !== 32'h0) begin n_fail++; $display("FAIL fill_done: got stall=%b rData=%h want 0/00000000", stall, rData); end
    n_checks++; if (memReadReq !== 1'b0) begin n_fail++; $display("FAIL fill_req_drop: got %b want 0", memReadReq); end
    tick();
    req(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
    n_checks++; if (stall !== 1'b0 || rData !== 32'h11111111) begin n_fail++; $display("FAIL hit_104: got stall=%b rData=%h want 0/11111111", stall, rData); end
    tick();
    req(1'b1, 1'b0, 1'b0, 32'h10C, 32'h0);
    n_checks++; if (rData !== 32'h33333333) begin n_fail++; $display("FAIL hit_10c: got %h want 33333333", rData); end
    n_checks++; if (memReadReq !== 1'b0 || memWriteReq !== 1'b0) begin n_fail++; $display("FAIL hit_no_mem: got rd=%b wr=%b want 0/0", memReadReq, memWriteReq); end
    tick();
  endtask

  task automatic test_store();
    req(1'b1, 1'b1, 1'b1, 32'h105, 32'hFFFFFFAB);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stb_stall: got %b want 0", stall); end
    tick();
    req(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
    n_checks++; if (rData !== 32'h1111AB11) begin n_fail++; $display("FAIL ldw_after_stb: got %h want 1111AB11", rData); end
    tick();
    req(1'b1, 1'b0, 1'b1, 32'h105, 32'h0);
    n_checks++; if (rData !== 32'h000000AB) begin n_fail++; $display("FAIL ldb_105: got %h want 000000AB", rData); end
    tick();
    req(1'b1, 1'b0, 1'b1, 32'h107, 32'h0);
    n_checks++; if (rData !== 32'h00000011) begin n_fail++; $display("FAIL ldb_107: got %h want 00000011", rData); end
    tick();
    req(1'b1, 1'b1, 1'b0, 32'h10B, 32'hCAFEF00D);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stw_stall: got %b want 0", stall); end
    tick();
    req(1'b1, 1'b0, 1'b0, 32'h108, 32'h0);
    n_checks++; if (rData !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ldw_after_stw: got %h want CAFEF00D", rData); end
    tick();
  endtask

  task automatic test_writeback();
    req(1'b1, 1'b0, 1'b0, 32'h140, 32'h0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wb_miss_stall: got %b want 1", stall); end
    tick();
    n_checks++; if (memWriteReq !== 1'b1 || memReadReq !== 1'b0) begin n_fail++; $display("FAIL wb_req: got wr=%b rd=%b want 1/0", memWriteReq, memReadReq); end
    n_checks++; if (memWriteAddr !== 32'h100) begin n_fail++; $display("FAIL wb_addr: got %h want 00000100", memWriteAddr); end
    n_checks++; if (memWriteData !== LINE_V) begin n_fail++; $display("FAIL wb_data: got %h want %h", memWriteData, LINE_V); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (stall !== 1'b1 || memWriteReq !== 1'b1 || memReadReq !== 1'b0 || memWriteAddr !== 32'h100) begin n_fail++; $display("FAIL wb_hold: got stall=%b wr=%b rd=%b addr=%h", stall, memWriteReq, memReadReq, memWriteAddr); end
    end
    memWriteDone = 1'b1;
    tick();
    memWriteDone = 1'b0;
    #1;
    n_checks++; if (memWriteReq !== 1'b0 || memReadReq !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL wb_to_fill: got wr=%b rd=%b stall=%b want 0/1/1", memWriteReq, memReadReq, stall); end
    n_checks++; if (memReadAddr !== 32'h140) begin n_fail++; $display("FAIL wb_fill_addr: got %h want 00000140", memReadAddr); end
    tick();
    fill_pulse(LINE_B);
    n_checks++; if (stall !== 1'b0 || rData !== 32'h44444444) begin n_fail++; $display("FAIL wb_fill_done: got stall=%b rData=%h want 0/44444444", stall, rData); end
    tick();
  endtask

  task automatic test_clean_conflict();
    req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    tick();
    n_checks++; if (memWriteReq !== 1'b0 || memReadReq !== 1'b1 || memReadAddr !== 32'h100) begin n_fail++; $display("FAIL refill_100: got wr=%b rd=%b addr=%h", memWriteReq, memReadReq, memReadAddr); end
    fill_pulse(LINE_V);
    n_checks++; if (rData !== 32'h0) begin n_fail++; $display("FAIL refill_100_data: got %h want 00000000", rData); end
    tick();
    req(1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    tick();
    n_checks++; if (memWriteReq !== 1'b0 || memReadReq !== 1'b1 || memReadAddr !== 32'h200) begin n_fail++; $display("FAIL clean_conflict: got wr=%b rd=%b addr=%h want 0/1/00000200", memWriteReq, memReadReq, memReadAddr); end
    fill_pulse(LINE_C);
    n_checks++; if (stall !== 1'b0 || rData !== 32'h88888888) begin n_fail++; $display("FAIL clean_fill_done: got stall=%b rData=%h want 0/88888888", stall, rData); end
    tick();
  endtask

  task automatic test_store_miss();
    req(1'b1, 1'b1, 1'b0, 32'h014, 32'h12345678);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stm_stall: got %b want 1", stall); end
    tick();
    n_checks++; if (memReadAddr !== 32'h010 || memReadReq !== 1'b1) begin n_fail++; $display("FAIL stm_fill: got rd=%b addr=%h want 1/00000010", memReadReq, memReadAddr); end
    fill_pulse(LINE_D);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stm_complete: got %b want 0", stall); end
    tick();
    req(1'b1, 1'b0, 1'b0, 32'h014, 32'h0);
    n_checks++; if (rData !== 32'h12345678) begin n_fail++; $display("FAIL stm_merged: got %h want 12345678", rData); end
    tick();
    req(1'b1, 1'b0, 1'b0, 32'h018, 32'h0);
    n_checks++; if (rData !== 32'hCCCCCCCC) begin n_fail++; $display("FAIL stm_neighbour: got %h want CCCCCCCC", rData); end
    tick();
  endtask

  task automatic test_reset_during_fill();
    req(1'b1, 1'b0, 1'b0, 32'h300, 32'h0);
    tick();
    n_checks++; if (memReadReq !== 1'b1 || memReadAddr !== 32'h300) begin n_fail++; $display("FAIL rst_fill_req: got rd=%b addr=%h", memReadReq, memReadAddr); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (memReadReq !== 1'b0 || memReadAddr !== 32'h0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_abort: got rd=%b addr=%h stall=%b", memReadReq, memReadAddr, stall); end
    fill_pulse(LINE_C);
    n_checks++; if (stall !== 1'b0 || memReadReq !== 1'b0) begin n_fail++; $display("FAIL late_ack: got stall=%b rd=%b want 0/0", stall, memReadReq); end
    req(1'b1, 1'b0, 1'b0, 32'h300, 32'h0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL late_ack_ignored: got stall=%b want 1", stall); end
    req(1'b1, 1'b0, 1'b0, 32'h014, 32'h0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL valid_cleared: got stall=%b want 1", stall); end
    req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL remiss_100: got stall=%b want 1", stall); end
    tick();
    n_checks++; if (memReadReq !== 1'b1 || memWriteReq !== 1'b0 || memReadAddr !== 32'h100) begin n_fail++; $display("FAIL remiss_fill: got rd=%b wr=%b addr=%h", memReadReq, memWriteReq, memReadAddr); end
    fill_pulse(LINE_E);
    n_checks++; if (rData !== 32'h0C0C0C0C) begin n_fail++; $display("FAIL remiss_data: got %h want 0C0C0C0C", rData); end
    tick();
  endtask

  task automatic test_idle_spurious();
    req(1'b0, 1'b0, 1'b0, 32'h104, 32'h0);
    memData = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      memDataValid = (i % 2 == 0) ? 1'b1 : 1'b0;
      memWriteDone = (i % 2 == 1) ? 1'b1 : 1'b0;
      #1;
      n_checks++; if (stall !== 1'b0 || rData !== 32'h0 || memReadReq !== 1'b0 || memWriteReq !== 1'b0) begin n_fail++; $display("FAIL idle_spurious: got stall=%b rData=%h rd=%b wr=%b", stall, rData, memReadReq, memWriteReq); end
      tick();
    end
    memDataValid = 1'b0; memWriteDone = 1'b0;
    req(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
    n_checks++; if (stall !== 1'b0 || rData !== 32'h0D0D0D0D) begin n_fail++; $display("FAIL idle_array_kept: got stall=%b rData=%h want 0/0D0D0D0D", stall, rData); end
    req(1'b1, 1'b0, 1'b0, 32'h014, 32'h0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL idle_no_fill: got stall=%b want 1", stall); end
    req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_b [4];
    exp_b[0] = 32'h04; exp_b[1] = 32'h03; exp_b[2] = 32'h02; exp_b[3] = 32'h01;
    req(1'b1, 1'b1, 1'b0, 32'h100, 32'h01020304);
    tick();
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 1'b0, 1'b1, 32'h100 + i, 32'h0);
      n_checks++; if (stall !== 1'b0 || rData !== exp_b[i]) begin n_fail++; $display("FAIL b2b_ldb_%0d: got stall=%b rData=%h want 0/%h", i, stall, rData, exp_b[i]); end
      tick();
    end
    req(1'b1, 1'b1, 1'b1, 32'h10F, 32'h000000EE);
    tick();
    req(1'b1, 1'b0, 1'b0, 32'h10C, 32'h0);
    n_checks++; if (rData !== 32'hEE0F0F0F) begin n_fail++; $display("FAIL b2b_stb_top: got %h want EE0F0F0F", rData); end
    tick();
    req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_fill_hit();
    test_store();
    test_writeback();
    test_clean_conflict();
    test_store_miss();
    test_reset_during_fill();
    test_idle_spurious();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_data.md
Name: cache_data

Overview:
- Direct-mapped, write-back, write-allocate data cache for the memory stage, between the ALU stage and write-back.
- Serves LDB/LDW/STB/STW using the ALU-computed address.
- Stalls the pipeline on a miss.
- Talks to the memory interface in 128-bit lines over separate read and write request/ack channels.

Parameters:
- ARCH_BITS, 32, address/data width.
- MEMORY_LINE_BITS, 128, cache line width (16 bytes).
- NUM_LINES, 4, number of lines; index width = log2(NUM_LINES).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset; rst==0 at a posedge resets.
- reqValid  in  1  memory op present this cycle.
- reqWrite  in  1  1 = store, 0 = load.
- reqByte  in  1  1 = byte access (LDB/STB), 0 = word (LDW/STW).
- reqAddr  in  ARCH_BITS  byte address from ALU.
- reqWData  in  ARCH_BITS  store data; byte stores use bits [7:0].
- rData  out  ARCH_BITS  load result; byte loads zero-extended.
- stall  out  1  1 = request not complete, pipeline must hold all inputs.
- memReadAddr  out  ARCH_BITS  line-aligned fill address.
- memReadReq  out  1  fill request.
- memData  in  MEMORY_LINE_BITS  fill line.
- memDataValid  in  1  one-cycle pulse; memData valid.
- memWriteAddr  out  ARCH_BITS  line-aligned victim address.
- memWriteData  out  MEMORY_LINE_BITS  victim line.
- memWriteReq  out  1  write-back request.
- memWriteDone  in  1  one-cycle pulse; write accepted.

Behaviour:
- Address split:
  - offset = reqAddr[3:0], index = reqAddr[3+IDX:4], tag = remaining upper bits.
  - Word select = reqAddr[3:2]; word accesses ignore reqAddr[1:0].
  - Byte lane = reqAddr[1:0]; byte 0 is line bits [7:0], little-endian.
- Per-line state: valid, dirty, tag, 128-bit data.
- Hit = reqValid & valid[index] & tag match. Lookup is combinational.
  - Load hit: rData driven the same cycle, stall=0.
  - Store hit: the selected word/byte is written and dirty set at the posedge; stall=0.
- stall = reqValid & ~hit & state==IDLE, and stall=1 in every non-IDLE state.
- When reqValid=0: stall=0, rData=0.
- FSM states IDLE, WBACK, FILL:
  - IDLE, miss, victim valid & dirty -> WBACK. memWriteAddr = {victimTag, index, 4'b0}, memWriteData = victim line.
  - IDLE, miss, otherwise -> FILL. memReadAddr = {reqAddr[31:4], 4'b0}.
  - WBACK: memWriteReq=1 with address/data held stable. On memWriteDone: clear dirty, -> FILL.
  - FILL: memReadReq=1 with address held stable. On memDataValid: write line, set valid, set tag, clear dirty, -> IDLE.
- The following cycle in IDLE hits and completes normally. A store merges into the line then and sets dirty.
- Miss penalty = write latency (if dirty) + read latency + 1 cycle.
- memReadReq and memWriteReq are never high together.
- A spurious memDataValid or memWriteDone outside the matching state is ignored.
- Inputs are stable while stall=1; the cache does not re-sample a changed request mid-miss.
- Reset (rst==0):
  - state=IDLE; all valid and dirty bits cleared.
  - memReadReq=0, memWriteReq=0, memReadAddr=0, memWriteAddr=0, memWriteData=0.
  - Reset during WBACK or FILL abandons the transaction: the write is lost, and a late ack is ignored.
  - Line data is not cleared.
- Address arithmetic is unsigned and truncated to ARCH_BITS.
- There is no exception or misalignment signalling.

Test Plan:
- Reset, then LDW 0x0000_0100:
  - memReadReq=1, memReadAddr=0x100.
  - Return line 0x..._33333333_22222222_11111111_00000000 -> stall drops the cycle after memDataValid; rData=0x00000000.
  - Then LDW 0x104 -> hit, rData=0x11111111, no memory request.
- After the fill above:
  - STB 0x105 with data 0xAB -> no stall.
  - LDW 0x104 -> rData=0x1111AB11.
  - LDB 0x105 -> rData=0x000000AB.
- Dirty line at 0x100, then LDW 0x140 (same index, new tag):
  - memWriteReq first, addr=0x100, data contains 0x1111AB11.
  - After memWriteDone: memReadReq, addr=0x140. stall held throughout; never both requests high.
- Clean-line conflict:
  - LDW 0x200 after a clean fill of 0x100 -> no write-back, direct FILL at 0x200.
- Reset asserted (rst=0) during FILL, then memDataValid arrives:
  - Ignored; the cache stays empty.
  - LDW 0x100 misses again.
- reqValid=0 for several cycles with memDataValid pulsed -> stall=0, state IDLE, no array change.
